// File: rtl/scan_mux_if.sv
// Bus bundle for scan_mux: mode/select/enable/data inputs and registered mux outputs.
// N and W must match the scan_mux instance this bundle is connected to.
interface scan_mux_if #(
  parameter int N = 8,
  parameter int W = 1
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic          mode;
  logic [SW-1:0] sel_in;
  logic [N-1:0]  en;
  logic [N*W-1:0] I;
  logic [W-1:0]  y;
  logic [SW-1:0] sel_out;
  logic          valid;
  logic          wrap;

  modport master (
    output mode, sel_in, en, I,
    input  y, sel_out, valid, wrap
  );

  modport slave (
    input  mode, sel_in, en, I,
    output y, sel_out, valid, wrap
  );
endinterface

// File: rtl/scan_mux.sv
// Registered N:1 channel mux with manual select or a dwell-timed scan over enabled channels.
// All outputs come straight from flops; rst is synchronous and active-high.
module scan_mux #(
  parameter int N     = 8,
  parameter int W     = 1,
  parameter int DWELL = 4,
  localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
  input logic        clk,
  input logic        rst,
  scan_mux_if.slave  bus
);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [SW-1:0] sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  y_q, y_d;
  logic          valid_q, valid_d;
  logic          wrap_q, wrap_d;

  logic [SW-1:0] up_idx, first_idx;
  logic          found_up, any_en;

  // An out-of-range sel_q never matches any k, so y/valid fall back to zero.
  always_comb begin
    y_d     = '0;
    valid_d = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (sel_q == SW'(k) && bus.en[k]) begin
        y_d     = bus.I[k*W +: W];
        valid_d = 1'b1;
      end
    end
  end

  // Lowest enabled index above sel_q, and lowest enabled index overall.
  always_comb begin
    up_idx    = '0;
    first_idx = '0;
    found_up  = 1'b0;
    any_en    = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (bus.en[k] && !any_en) begin
        first_idx = SW'(k);
        any_en    = 1'b1;
      end
      if (bus.en[k] && !found_up && (SW'(k) > sel_q)) begin
        up_idx   = SW'(k);
        found_up = 1'b1;
      end
    end
  end

  always_comb begin
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (!bus.mode) begin
      sel_d = bus.sel_in;
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
      if (found_up) begin
        sel_d = up_idx;
      end else if (any_en) begin
        sel_d  = first_idx;
        wrap_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.sel_out = sel_q;
  assign bus.valid   = valid_q;
  assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: scenario tasks plus a queue-based reference model.
module tb_scan_mux;
  localparam int N = 8, W = 1, DWELL = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scan_mux_if #(.N(N), .W(W)) bus ();
  scan_mux #(.N(N), .W(W), .DWELL(DWELL)) dut (.clk(clk), .rst(rst), .bus(bus));

  scan_mux_if #(.N(6), .W(1)) bus6 ();
  scan_mux #(.N(6), .W(1), .DWELL(DWELL)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

  scan_mux_if #(.N(10), .W(1)) bus10 ();
  scan_mux #(.N(10), .W(1), .DWELL(DWELL)) dut10 (.clk(clk), .rst(rst), .bus(bus10));

  int vectors = 0;
  int errors  = 0;

  int         m_sel, m_cnt;
  logic [W-1:0] m_y;
  logic       m_valid, m_wrap;
  logic [5:0] got, exp;

  // One clock edge: latch the applied inputs, advance the model, then settle.
  task automatic step();
    logic         r, md;
    logic [2:0]   si;
    logic [N-1:0] e;
    logic [N*W-1:0] d;
    int lst[$];
    int nxt;
    r = rst; md = bus.mode; si = bus.sel_in; e = bus.en; d = bus.I;
    @(posedge clk);
    if (r) begin
      m_sel = 0; m_cnt = 0; m_y = '0; m_valid = 1'b0; m_wrap = 1'b0;
    end else begin
      if (m_sel < N && e[m_sel]) begin
        m_y = d[m_sel*W +: W]; m_valid = 1'b1;
      end else begin
        m_y = '0; m_valid = 1'b0;
      end
      m_wrap = 1'b0;
      if (!md) begin
        m_sel = int'(si); m_cnt = 0;
      end else if (m_cnt < DWELL - 1) begin
        m_cnt++;
      end else begin
        m_cnt = 0;
        for (int k = 0; k < N; k++) if (e[k]) lst.push_back(k);
        if (lst.size() > 0) begin
          nxt = -1;
          foreach (lst[j]) if (lst[j] > m_sel && nxt < 0) nxt = lst[j];
          if (nxt >= 0) m_sel = nxt;
          else begin m_sel = lst[0]; m_wrap = 1'b1; end
        end
      end
    end
    #1;
    got = {bus.y, bus.valid, bus.sel_out, bus.wrap};
    exp = {m_y, m_valid, 3'(m_sel), m_wrap};
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.mode = 1'b1; bus.I = '1; bus.en = '1; bus.sel_in = '0;
    repeat (2) begin
      step();
      vectors++;
      if (got !== 6'b0) begin
        errors++;
        $display("FAIL reset_state got=%b exp=%b", got, 6'b0);
      end
    end
    rst = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      step();
      vectors++;
      if (bus.sel_out !== ((j == 4) ? 3'd1 : 3'd0) || got !== exp) begin
        errors++;
        $display("FAIL reset_release step=%0d got=%b exp=%b", j, got, exp);
      end
    end
  endtask

  task automatic test_manual_sweep();
    bus.mode = 1'b0; bus.en = 8'hFF;
    for (int s = 0; s < N; s++) begin
      bus.sel_in = 3'(s);
      for (int p = 0; p < 2; p++) begin
        bus.I = (p == 0) ? 8'h00 : 8'hFF;
        for (int c = 0; c < 5; c++) begin
          step();
          vectors++;
          if (got !== exp || (c > 0 && (bus.y !== 1'(p) || bus.valid !== 1'b1))) begin
            errors++;
            $display("FAIL manual_sweep s=%0d p=%0d c=%0d got=%b exp=%b", s, p, c, got, exp);
          end
        end
      end
    end
  endtask

  task automatic test_manual_latency();
    logic [7:0] pat;
    int prev, s;
    bus.mode = 1'b0; bus.en = 8'hFF;
    pat = 8'b0110_1001; bus.I = pat;
    prev = 0; bus.sel_in = 3'd0;
    repeat (2) step();
    for (int t = 0; t < 8; t++) begin
      do s = $urandom_range(7); while (pat[s] == pat[prev]);
      bus.sel_in = 3'(s);
      step();
      vectors++;
      if (bus.y !== pat[prev] || bus.sel_out !== 3'(s)) begin
        errors++;
        $display("FAIL sel_latency_e1 s=%0d y=%b exp=%b sel=%0d", s, bus.y, pat[prev], bus.sel_out);
      end
      step();
      vectors++;
      if (bus.y !== pat[s] || got !== exp) begin
        errors++;
        $display("FAIL sel_latency_e2 s=%0d y=%b exp=%b", s, bus.y, pat[s]);
      end
      prev = s;
    end
  endtask

  task automatic test_scan_full();
    int sp;
    rst = 1'b1; step(); rst = 1'b0;
    bus.mode = 1'b1; bus.en = 8'hFF; bus.I = 8'b1010_1010;
    sp = 0;
    for (int j = 1; j <= 36; j++) begin
      step();
      vectors++;
      if (bus.sel_out !== 3'((j / 4) % 8) || bus.wrap !== (j == 32) ||
          bus.y !== 1'(sp % 2) || got !== exp) begin
        errors++;
        $display("FAIL scan_full j=%0d got=%b exp=%b", j, got, exp);
      end
      sp = (j / 4) % 8;
    end
  endtask

  task automatic test_sparse_masks();
    int wraps;
    rst = 1'b1; step(); rst = 1'b0;
    bus.mode = 1'b1; bus.en = 8'b0100_0010; bus.I = $urandom;
    wraps = 0;
    for (int j = 1; j <= 20; j++) begin
      bus.I = $urandom;
      step();
      wraps += int'(bus.wrap);
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL sparse_1_6 j=%0d got=%b exp=%b", j, got, exp);
      end
    end
    vectors++;
    if (wraps != 2 || bus.sel_out !== 3'd1) begin
      errors++;
      $display("FAIL sparse_wraps wraps=%0d sel=%0d exp wraps=2 sel=1", wraps, bus.sel_out);
    end
    rst = 1'b1; step(); rst = 1'b0;
    bus.en = 8'b0000_1000; wraps = 0;
    for (int j = 1; j <= 12; j++) begin
      step();
      wraps += int'(bus.wrap);
      vectors++;
      if (got !== exp || (j >= 4 && bus.sel_out !== 3'd3) || bus.wrap !== (j == 8 || j == 12)) begin
        errors++;
        $display("FAIL single_en j=%0d got=%b exp=%b", j, got, exp);
      end
    end
    bus.en = 8'h00;
    for (int j = 1; j <= 12; j++) begin
      step();
      vectors++;
      if (got !== exp || bus.sel_out !== 3'd3 || bus.valid !== 1'b0 || bus.wrap !== 1'b0) begin
        errors++;
        $display("FAIL en_zero j=%0d got=%b exp=%b", j, got, exp);
      end
    end
  endtask

  task automatic test_mode_switch();
    bus.mode = 1'b0; bus.sel_in = 3'd5; bus.en = 8'hFF;
    step();
    bus.mode = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step();
      vectors++;
      if (bus.sel_out !== ((j == 4) ? 3'd6 : 3'd5) || got !== exp) begin
        errors++;
        $display("FAIL manual_to_scan j=%0d sel=%0d got=%b exp=%b", j, bus.sel_out, got, exp);
      end
    end
    bus.mode = 1'b0; bus.sel_in = 3'd2;
    step();
    vectors++;
    if (bus.sel_out !== 3'd2 || got !== exp) begin
      errors++;
      $display("FAIL scan_to_manual sel=%0d exp=2", bus.sel_out);
    end
  endtask

  task automatic test_reset_mid_scan();
    rst = 1'b1; step(); rst = 1'b0;
    bus.mode = 1'b1; bus.en = 8'hFF; bus.I = 8'hFF;
    repeat (22) step();
    rst = 1'b1; bus.en = 8'b1111_1110;
    step();
    vectors++;
    if (bus.sel_out !== 3'd0 || bus.y !== 1'b0 || got !== exp) begin
      errors++;
      $display("FAIL reset_mid sel=%0d y=%b exp sel=0 y=0", bus.sel_out, bus.y);
    end
    rst = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      step();
      vectors++;
      if (bus.sel_out !== ((j >= 4) ? 3'd1 : 3'd0) || bus.valid !== (j == 5) || got !== exp) begin
        errors++;
        $display("FAIL reset_mid_dwell j=%0d got=%b exp=%b", j, got, exp);
      end
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 400; j++) begin
      rst = ($urandom_range(49) == 0);
      if ($urandom_range(15) == 0) bus.mode = ~bus.mode;
      if ($urandom_range(7) == 0) bus.en = $urandom;
      bus.sel_in = $urandom;
      bus.I = $urandom;
      step();
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random j=%0d got=%b exp=%b", j, got, exp);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_range();
    logic [9:0] d10;
    d10 = $urandom;
    bus6.mode = 1'b0; bus6.en = '1; bus6.I = 6'b11_1111; bus6.sel_in = 3'd7;
    bus10.mode = 1'b0; bus10.en = '1; bus10.I = d10; bus10.sel_in = 4'd9;
    repeat (3) step();
    vectors++;
    if (bus6.y !== 1'b0 || bus6.valid !== 1'b0 || bus6.sel_out !== 3'd7) begin
      errors++;
      $display("FAIL range_n6 y=%b valid=%b sel=%0d exp 0 0 7", bus6.y, bus6.valid, bus6.sel_out);
    end
    vectors++;
    if (bus10.y !== d10[9] || bus10.valid !== 1'b1 || bus10.sel_out !== 4'd9) begin
      errors++;
      $display("FAIL range_n10 y=%b valid=%b exp y=%b valid=1", bus10.y, bus10.valid, d10[9]);
    end
    bus6.sel_in = 3'd5;
    repeat (2) step();
    vectors++;
    if (bus6.y !== 1'b1 || bus6.valid !== 1'b1) begin
      errors++;
      $display("FAIL range_n6_in y=%b valid=%b exp 1 1", bus6.y, bus6.valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.mode = 1'b0; bus.sel_in = '0; bus.en = '0; bus.I = '0;
    bus6.mode = 1'b0; bus6.sel_in = '0; bus6.en = '0; bus6.I = '0;
    bus10.mode = 1'b0; bus10.sel_in = '0; bus10.en = '0; bus10.I = '0;
    m_sel = 0; m_cnt = 0; m_y = '0; m_valid = 1'b0; m_wrap = 1'b0;
    #2;
    test_reset();
    test_manual_sweep();
    test_manual_latency();
    test_scan_full();
    test_sparse_masks();
    test_mode_switch();
    test_reset_mid_scan();
    test_random();
    test_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/scan_mux.md
# scan_mux

Parametrised, registered N:1 channel multiplexer with two select modes. In manual mode, an external select drives the output. In scan mode, an internal sequencer steps through the enabled channels, holding each one for a programmable number of cycles. It is the clocked successor of the 8:1 decoder/tristate mux and sits between a bank of N sources and a single downstream consumer that needs either fixed or time-multiplexed access.

## Interface
- N, 8: number of input channels (≥2).
- W, 1: data width per channel.
- SW, $clog2(N): select width (derived; do not override).
- DWELL, 4: cycles each channel is held in scan mode (≥1).

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = manual, 1 = scan.
- sel_in  input  SW  manual channel select.
- en  input  N  per-channel enable mask; bit k enables channel k.
- I  input  N*W  channel data; channel k is I[k*W +: W].
- y  output  W  registered selected data.
- sel_out  output  SW  current registered select (sel_q).
- valid  output  1  y is from an enabled, in-range channel.
- wrap  output  1  one-cycle pulse when the scan sequence wraps.

## Operation
- Reset (rst=1 at an edge) sets the outputs and internal state as follows:
  - sel_q=0, dwell counter=0
  - y=0, valid=0, wrap=0
  - rst has priority over all other inputs.
- Datapath, every non-reset edge:
  - y <= I[sel_q*W +: W], using the sel_q value from before the edge.
  - valid <= (sel_q < N) && en[sel_q].
  - If that condition is false, y <= 0.
- Manual mode (mode=0):
  - sel_q <= sel_in every edge.
  - If sel_in ≥ N, sel_q still loads. The next y is 0 and valid is 0.
  - The dwell counter is held at 0.
  - wrap is always 0.
- Scan mode (mode=1), dwell counter behaviour:
  - The counter counts 0..DWELL-1.
  - While counter < DWELL-1: counter increments and sel_q holds.
  - When counter = DWELL-1: counter goes to 0 and sel_q advances.
- Scan mode, advance rule:
  - sel_q moves to the lowest enabled index strictly greater than sel_q.
  - If no such index exists, sel_q moves to the lowest enabled index overall, and wrap pulses high for one cycle on that same edge.
  - Exactly one enabled channel: sel_q stays on it, and wrap pulses every DWELL cycles.
  - en all-zero: sel_q holds, the counter keeps running, and wrap stays 0.
- Scan mode, boundary cases:
  - If the current channel is disabled mid-dwell, the dwell is not cut short. valid drops per the datapath rule until the next advance.
  - If sel_q ≥ N on entry to scan mode (left over from manual), the first advance goes to the lowest enabled index and pulses wrap.
- Mode switching:
  - Manual→scan: the counter starts at 0 on the first scan edge, and scanning starts from the current sel_q.
  - Scan→manual: on the first manual edge sel_q <= sel_in and the counter clears.
- en and mode are sampled only at the edge. There is no combinational path from any input to any output.

## Timing
- Data latency: a change on I reaches y 1 edge later.
- Manual select latency: sel_in is captured into sel_q at edge t. y and valid reflect the new channel after edge t+1, i.e. 2 edges.
- Scan: each channel's data appears on y for exactly DWELL consecutive cycles, delayed 1 cycle relative to sel_out.
- wrap aligns with the sel_out update of the wrapping edge, not with y.
- Reset mid-scan:
  - The next edge after rst deasserts behaves as the first edge from reset state: sel_q=0, counter=0.
  - In scan mode, channel 0 is held for a full DWELL even if en[0]=0, with valid=0 during that dwell.

## Test plan
- Reset: hold rst 2 cycles with I=all-ones, mode=1 -> y=0, valid=0, wrap=0, sel_out=0 throughout. After release, sel_out=0 for 4 cycles (DWELL=4).
- Manual sweep (N=8, W=1, en=8'hFF): for s=0..7, set sel_in=s, I=8'h00 for 5 cycles, then I=8'hFF for 5 cycles.
  - Required: y=0 then y=1, with y switching 1 edge after I, and valid=1.
  - Required: sel_in → y latency is exactly 2 edges.
- Scan full mask (DWELL=4, en=8'hFF, I=8'b1010_1010):
  - Required: sel_out steps 0,1,…,7,0, each held 4 cycles, and y follows 0,1,0,1,… with a 1-cycle lag.
  - Required: wrap is high for exactly one cycle when sel_out returns from 7 to 0.
- Sparse and edge masks:
  - en=8'b0100_0010: required sequence 1,6,1,6 with wrap on each 6→1.
  - en=8'b0000_1000: sel_out stays 3, with wrap every 4 cycles.
  - en=0: sel_out frozen, valid=0, wrap=0.
- Mode switch and range:
  - In manual, sel_in=5, then switch to scan with en=8'hFF -> sel_out=5 for 4 cycles, then 6.
  - Manual sel_in=9 with N=10 is in range and passes. With N=8 and sel_in=3'b111 there is no out-of-range value.
  - Out-of-range check with N=6, sel_in=7: required y=0, valid=0.
- Reset mid-scan: assert rst while sel_out=5 with the counter at 2 -> next cycle sel_out=0, y=0, and a fresh 4-cycle dwell on channel 0 follows.
